// File: rtl/data_cache_dm_burst_if.sv
// Core-side request/response and memory-side handshake bundle for data_cache_dm_burst.
// Handshake: a memory request transfers on a rising edge where mem_req_valid && mem_req_ready; once
// mem_req_valid is raised, all mem_req_* hold stable until that edge. mem_rsp_valid has no back-pressure.
interface data_cache_dm_burst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req_valid;
  logic                  cpu_we;
  logic [2:0]            cpu_funct3;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_flush;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic                  cpu_misaligned;
  logic                  mem_req_valid;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [3:0]            mem_req_wstrb;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  // The cache itself.
  modport slave (
    input  cpu_req_valid, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, cpu_flush,
    output cpu_rdata, cpu_stall, cpu_misaligned,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  // The surrounding core and memory.
  modport master (
    output cpu_req_valid, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, cpu_flush,
    input  cpu_rdata, cpu_stall, cpu_misaligned,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/data_cache_dm_burst.sv
// Direct-mapped, write-through, write-no-allocate data cache with multi-word lines.
// Load misses refill the whole line one beat at a time; stores always go to memory with strobes.
module data_cache_dm_burst #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_cache_dm_burst_if.slave bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [1:0]           dbg_state
);
  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int LW = IW + WW;
  localparam int TW = ADDR_WIDTH - 2 - LW;
  localparam int BW = (WW > 0) ? WW : 1;
  localparam logic [ADDR_WIDTH-3:0] WORD_MASK = (ADDR_WIDTH-2)'(WORDS_PER_LINE - 1);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REFILL_REQ = 2'd1, REFILL_RSP = 2'd2, WRITE = 2'd3} state_t;

  state_t                state;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TW-1:0]         tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES*WORDS_PER_LINE];
  logic [BW-1:0]         beat;

  logic [TW-1:0]         req_tag;
  logic [IW-1:0]         req_idx;
  logic [LW-1:0]         req_word_ix;
  logic [LW-1:0]         beat_ix;
  logic [ADDR_WIDTH-3:0] word_base;
  logic                  line_hit, misalign, idle_req, accept;
  logic [3:0]            st_wstrb;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  unused_funct3;

  assign req_tag     = bus.cpu_addr[ADDR_WIDTH-1 -: TW];
  assign req_idx     = bus.cpu_addr[2+WW +: IW];
  assign req_word_ix = bus.cpu_addr[2 +: LW];
  assign word_base   = bus.cpu_addr[ADDR_WIDTH-1:2] & ~WORD_MASK;
  assign beat_ix     = (req_word_ix & ~LW'(WORDS_PER_LINE - 1)) | LW'(beat);
  assign line_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_funct3 = bus.cpu_funct3[2];

  // Loads ignore funct3[2] (unsigned variants); the returned word is always the aligned word.
  assign misalign = ((bus.cpu_funct3[1:0] == 2'b01) && bus.cpu_addr[0]) ||
                    (bus.cpu_funct3[1] && (bus.cpu_addr[1:0] != 2'b00));
  assign idle_req = (state == IDLE) && bus.cpu_req_valid && !bus.cpu_flush;
  assign accept   = idle_req && !misalign;

  assign bus.cpu_misaligned = idle_req && misalign;
  assign bus.cpu_rdata      = data_q[req_word_ix];
  assign dbg_state          = state;

  always_comb begin
    bus.cpu_stall = 1'b1;
    case (state)
      IDLE:    bus.cpu_stall = bus.cpu_flush || (accept && (bus.cpu_we || !line_hit));
      WRITE:   bus.cpu_stall = !bus.mem_req_ready;
      default: bus.cpu_stall = 1'b1;
    endcase
  end

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = bus.cpu_wdata;
    case (bus.cpu_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << bus.cpu_addr[1:0];
        st_wdata = {4{bus.cpu_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << bus.cpu_addr[1:0];
        st_wdata = {2{bus.cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      valid_q           <= '0;
      beat              <= '0;
      hit_count         <= '0;
      miss_count        <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_we    <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_wdata <= '0;
      bus.mem_req_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_flush) begin
            valid_q <= '0;
          end else if (accept) begin
            if (bus.cpu_we) begin
              state             <= WRITE;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b1;
              bus.mem_req_addr  <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_req_wdata <= st_wdata;
              bus.mem_req_wstrb <= st_wstrb;
            end else if (line_hit) begin
              if (~&hit_count) hit_count <= hit_count + 1'b1;
            end else begin
              if (~&miss_count) miss_count <= miss_count + 1'b1;
              valid_q[req_idx]  <= 1'b0;
              beat              <= '0;
              state             <= REFILL_REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we    <= 1'b0;
              bus.mem_req_wstrb <= 4'b0000;
              bus.mem_req_addr  <= {word_base, 2'b00};
            end
          end
        end
        REFILL_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= REFILL_RSP;
          end
        end
        REFILL_RSP: begin
          if (bus.mem_rsp_valid) begin
            if (beat == LAST_BEAT) begin
              valid_q[req_idx] <= 1'b1;
              state            <= IDLE;
            end else begin
              beat              <= beat + 1'b1;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {word_base | (ADDR_WIDTH-2)'(beat + 1'b1), 2'b00};
              state             <= REFILL_REQ;
            end
          end
        end
        WRITE: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (state == REFILL_RSP && bus.mem_rsp_valid) begin
      data_q[beat_ix] <= bus.mem_rsp_rdata;
      if (beat == LAST_BEAT) tag_q[req_idx] <= req_tag;
    end
    if (state == WRITE && bus.mem_req_ready && line_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_req_wstrb[i]) data_q[req_word_ix][8*i +: 8] <= bus.mem_req_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_cache_dm_burst.sv
// Directed bench for data_cache_dm_burst: a randomly-stalling memory model checks every
// memory request against an expected queue; loads, stores, flush and reset are checked inline.
module tb_data_cache_dm_burst;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hit_count, miss_count;
  logic [1:0]  dbg_state;

  int          total = 0;
  int          bad = 0;
  int          rd_hs = 0;
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;
  logic [68:0] exp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  data_cache_dm_burst_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_cache_dm_burst #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LINES(8), .WORDS_PER_LINE(4), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [68:0] obs, input logic [68:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = mem_rd(a);
    mem_model[a] = (cur & ~lane_mask(s)) | (d & lane_mask(s));
  endtask

  // Memory model: random ready, one outstanding read, response after 0..2 idle cycles.
  initial begin : responder
    logic        rsp_pending, held;
    int          rsp_delay;
    logic [31:0] rsp_data;
    logic [68:0] obs, held_req;
    rsp_pending = 1'b0; held = 1'b0; rsp_delay = 0; rsp_data = '0; held_req = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        rsp_pending = 1'b0;
        held = 1'b0;
      end else begin
        if (rsp_pending) begin
          if (rsp_delay == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = rsp_data;
            rsp_pending = 1'b0;
          end else rsp_delay--;
        end
        obs = {bus.mem_req_we, bus.mem_req_addr,
               bus.mem_req_we ? (bus.mem_req_wdata & lane_mask(bus.mem_req_wstrb)) : 32'h0,
               bus.mem_req_we ? bus.mem_req_wstrb : 4'h0};
        if (bus.mem_req_valid) begin
          if (held) chk("req_stable", obs, held_req);
          bus.mem_req_ready = ($urandom_range(0, 2) != 0);
          if (bus.mem_req_ready) begin
            held = 1'b0;
            chk("req_expected", 69'(exp_q.size() > 0), 69'd1);
            if (exp_q.size() > 0) chk("req_content", obs, exp_q.pop_front());
            if (bus.mem_req_we) mem_wr(bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb);
            else begin
              rsp_pending = 1'b1;
              rsp_delay   = $urandom_range(0, 2);
              rsp_data    = mem_rd(bus.mem_req_addr);
              rd_hs++;
            end
          end else begin
            held = 1'b1;
            held_req = obs;
          end
        end else begin
          if (held) chk("req_dropped", 69'(bus.mem_req_valid), 69'd1);
          held = 1'b0;
        end
      end
    end
  end

  task automatic push_refill(input logic [31:0] a);
    for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, (a & ~32'hF) + 32'(4 * b), 32'h0, 4'h0});
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp_data, input bit exp_miss,
                         input string name);
    int cyc;
    cyc = 0;
    if (exp_miss) begin
      push_refill(a);
      exp_misses++;
    end
    exp_hits++;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010; bus.cpu_addr = a;
    #1;
    while (bus.cpu_stall && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    chk({name, "_timeout"}, 69'(cyc < 100), 69'd1);
    chk({name, "_stalled"}, 69'(cyc > 0), 69'(exp_miss));
    chk({name, "_rdata"}, 69'(bus.cpu_rdata), 69'(exp_data));
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    chk({name, "_hits"}, 69'(hit_count), 69'(exp_hits));
    chk({name, "_misses"}, 69'(miss_count), 69'(exp_misses));
    chk({name, "_memq"}, 69'(exp_q.size()), 69'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_wd, input logic [3:0] exp_strb, input string name);
    int cyc;
    cyc = 0;
    exp_q.push_back({1'b1, a & ~32'h3, exp_wd & lane_mask(exp_strb), exp_strb});
    @(negedge clk);
    bus.cpu_req_valid = 1'b1; bus.cpu_we = 1'b1; bus.cpu_funct3 = f3; bus.cpu_addr = a;
    bus.cpu_wdata = wd;
    #1;
    chk({name, "_stall_idle"}, 69'(bus.cpu_stall), 69'd1);
    while (bus.cpu_stall && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    chk({name, "_timeout"}, 69'(cyc < 100), 69'd1);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0; bus.cpu_we = 1'b0;
    chk({name, "_memq"}, 69'(exp_q.size()), 69'd0);
    chk({name, "_hits"}, 69'(hit_count), 69'(exp_hits));
    chk({name, "_misses"}, 69'(miss_count), 69'(exp_misses));
  endtask

  task automatic do_misaligned(input logic [31:0] a, input logic [2:0] f3, input logic we,
                               input string name);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1; bus.cpu_we = we; bus.cpu_funct3 = f3; bus.cpu_addr = a;
    bus.cpu_wdata = 32'h1234_5678;
    #1;
    chk({name, "_flag"}, 69'(bus.cpu_misaligned), 69'd1);
    chk({name, "_stall"}, 69'(bus.cpu_stall), 69'd0);
    chk({name, "_memreq"}, 69'(bus.mem_req_valid), 69'd0);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0; bus.cpu_we = 1'b0;
    chk({name, "_state"}, 69'(dbg_state), 69'd0);
    chk({name, "_hits"}, 69'(hit_count), 69'(exp_hits));
    chk({name, "_misses"}, 69'(miss_count), 69'(exp_misses));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_stall"}, 69'(bus.cpu_stall), 69'd0);
    chk({name, "_misaligned"}, 69'(bus.cpu_misaligned), 69'd0);
    chk({name, "_memreq"}, 69'(bus.mem_req_valid), 69'd0);
    chk({name, "_hits"}, 69'(hit_count), 69'd0);
    chk({name, "_misses"}, 69'(miss_count), 69'd0);
    chk({name, "_state"}, 69'(dbg_state), 69'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int cyc, base;
    rst_n = 1'b0;
    bus.cpu_req_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_flush = 1'b0;
    mem_model[32'h40] = 32'h11; mem_model[32'h44] = 32'h22;
    mem_model[32'h48] = 32'h33; mem_model[32'h4C] = 32'h44;
    mem_model[32'h80] = 32'hA0; mem_model[32'h84] = 32'hA4;
    mem_model[32'h88] = 32'hA8; mem_model[32'h8C] = 32'hAC;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_load(32'h40, 32'h11, 1'b1, "ld40_refill");
    do_load(32'h44, 32'h22, 1'b0, "ld44_hit");
    do_load(32'h48, 32'h33, 1'b0, "ld48_hit");
    do_load(32'h4C, 32'h44, 1'b0, "ld4c_hit");

    do_store(32'h41, 3'b000, 32'h0000_00AB, 32'h0000_AB00, 4'b0010, "sb41");
    do_load(32'h40, 32'h0000_AB11, 1'b0, "ld40_after_sb");

    do_store(32'h1000, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, "sw1000");
    do_load(32'h1000, 32'hDEAD_BEEF, 1'b1, "ld1000_noalloc");

    do_load(32'h40, 32'h0000_AB11, 1'b0, "ld40_pre_conflict");
    do_load(32'hC0, mem_rd(32'hC0), 1'b1, "ldc0_evict");
    do_load(32'h40, 32'h0000_AB11, 1'b1, "ld40_evicted");

    do_misaligned(32'h43, 3'b001, 1'b1, "sh43_mis");
    do_misaligned(32'h42, 3'b010, 1'b0, "lw42_mis");

    // Flush together with a load: the flush wins, the load is re-presented and misses.
    @(negedge clk);
    bus.cpu_flush = 1'b1; bus.cpu_req_valid = 1'b1; bus.cpu_we = 1'b0;
    bus.cpu_funct3 = 3'b010; bus.cpu_addr = 32'h40;
    #1;
    chk("flush_stall", 69'(bus.cpu_stall), 69'd1);
    chk("flush_no_memreq", 69'(bus.mem_req_valid), 69'd0);
    @(posedge clk); #1;
    bus.cpu_flush = 1'b0; bus.cpu_req_valid = 1'b0;
    chk("flush_hits", 69'(hit_count), 69'(exp_hits));
    chk("flush_misses", 69'(miss_count), 69'(exp_misses));
    do_load(32'h40, 32'h0000_AB11, 1'b1, "ld40_after_flush");

    // Reset while the third beat's response is outstanding.
    push_refill(32'h80);
    base = rd_hs;
    cyc = 0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'b010; bus.cpu_addr = 32'h80;
    #1;
    while (rd_hs < base + 3 && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    chk("rst_mid_wait", 69'(cyc < 200), 69'd1);
    @(posedge clk); #1;
    chk("rst_mid_state", 69'(dbg_state), 69'd2);
    rst_n = 1'b0;
    bus.cpu_req_valid = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    do_load(32'h80, 32'hA0, 1'b1, "ld80_after_rst");
    do_load(32'h8C, 32'hAC, 1'b0, "ld8c_after_rst");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_cache_dm_burst.md
Name: data_cache_dm_burst

Overview:
- Parametrised direct-mapped, write-through, write-no-allocate data cache with multi-word lines, between the core's memory stage and a handshaked data-memory port.
- Load hits return in the same cycle; load misses refill a whole line, one word per beat.
- Stores update the line on a hit and are always forwarded to memory with byte strobes.
- Adds reset, flush, a stall output and saturating hit/miss counters.

Parameters:
ADDR_WIDTH  32  byte address width
DATA_WIDTH  32  word width; only 32 is supported (4 byte lanes)
NUM_LINES  8  number of lines, power of two >= 2
WORDS_PER_LINE  4  words per line, power of two >= 1
CNT_WIDTH  32  hit/miss counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  access request this cycle
cpu_we  in  1  1 = store, 0 = load
cpu_funct3  in  3  RV32 size: 000 B, 001 H, 010 W (loads: bit 2 ignored)
cpu_addr  in  ADDR_WIDTH  byte address
cpu_wdata  in  DATA_WIDTH  store data, right-aligned
cpu_flush  in  1  invalidate all lines
cpu_rdata  out  DATA_WIDTH  aligned word containing cpu_addr
cpu_stall  out  1  core must hold request stable
cpu_misaligned  out  1  request rejected as misaligned
mem_req_valid  out  1  memory request
mem_req_we  out  1  memory write
mem_req_addr  out  ADDR_WIDTH  word-aligned memory address
mem_req_wdata  out  DATA_WIDTH  store data shifted to byte lane
mem_req_wstrb  out  4  byte strobes
mem_req_ready  in  1  memory accepts request this cycle
mem_rsp_valid  in  1  read data valid, in order
mem_rsp_rdata  in  DATA_WIDTH  read data
hit_count  out  CNT_WIDTH  load hits, saturating
miss_count  out  CNT_WIDTH  load misses, saturating

Behaviour:
- Address split: offset[1:0] byte; word = log2(WORDS_PER_LINE) bits; index = log2(NUM_LINES) bits; tag = remainder.
- Reset (async, rst_n=0): all valid bits 0, state IDLE, counters 0, mem_req_valid=0, cpu_stall=0, cpu_misaligned=0, beat counter 0. Data arrays need no reset.
- Reset mid-refill or mid-write: transaction abandoned; any late mem_rsp_valid after reset is ignored in IDLE.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0.
  - Request is dropped and cpu_misaligned=1 combinationally in IDLE.
  - No stall, no memory traffic, no counter change.
- FSM states: IDLE, REFILL_REQ, REFILL_RSP, WRITE.
- IDLE, load hit (valid && tag match):
  - cpu_rdata = cached word, cpu_stall=0, hit_count+1.
- IDLE, load miss:
  - cpu_stall=1, miss_count+1, beat<=0, go to REFILL_REQ.
  - The line's valid bit is cleared on entry.
- REFILL_REQ:
  - mem_req_valid=1, we=0, addr = {tag,index,beat,2'b00}.
  - On mem_req_ready go to REFILL_RSP.
- REFILL_RSP:
  - On mem_rsp_valid, write word[beat].
  - If beat==WORDS_PER_LINE-1: set tag and valid, go to IDLE. Otherwise beat+1 and go back to REFILL_REQ.
  - Only one outstanding read at a time.
- After refill, IDLE re-evaluates and hits.
  - Miss latency = 1 + sum of per-beat memory latencies + 1 cycle; cpu_stall is high throughout.
  - The completing access counts as a hit as well as a miss.
- IDLE, store (aligned): cpu_stall=1, go to WRITE.
- WRITE:
  - mem_req_valid=1, we=1, addr word-aligned.
  - wstrb: B = 1<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
  - wdata replicated/shifted to the lane.
  - cpu_stall = !mem_req_ready.
  - On handshake: if line valid and tag matches, update only the strobed bytes; go to IDLE.
  - A store miss does not allocate. Stores do not change the counters.
- cpu_flush:
  - Honoured only in IDLE; clears all valid bits next edge and takes priority over a same-cycle request.
  - cpu_stall=1 that cycle, so the request is re-presented.
  - Ignored in other states.
- mem_req_* outputs hold stable while mem_req_valid=1 and ready=0.
- Counters saturate at all-ones.
- cpu_rdata outside load-hit cycles is don't-care. The bench must not check it.
- cpu_req_valid=0 in IDLE: no action, stall=0.

Test Plan:
- Reset, then load W 0x0000_0040; memory returns 0x11,0x22,0x33,0x44 for 0x40..0x4C.
  - Required: 4 read beats at ascending addresses, stall high until refill, then rdata=0x11, miss_count=1, hit_count=1.
  - Loads of 0x44, 0x48, 0x4C then hit in 0 cycles with 0x22, 0x33, 0x44.
- After refill above, SB 0xAB to 0x0000_0041.
  - Required: mem write with wstrb=0010, wdata[15:8]=0xAB.
  - Next load W 0x40 hits with 0x0000AB11.
- SW 0xDEADBEEF to uncached 0x0000_1000.
  - Required: one mem write with wstrb=1111.
  - Next load of 0x1000 misses (no allocate), miss_count increments.
- Conflict: load 0x40 then 0x0000_0040+NUM_LINES*WORDS_PER_LINE*4 (0xC0 with defaults).
  - Required: second load refills and evicts; reloading 0x40 misses again.
- SH to 0x43, then LW at 0x42.
  - Required: cpu_misaligned=1 on both, no stall, no mem_req_valid, counters unchanged.
- Assert rst_n=0 during REFILL_RSP beat 2, release, then load the same address.
  - Required: outputs at reset values, line invalid, full 4-beat refill repeats.
- cpu_flush in IDLE with a valid line.
  - Required: the following load to that line misses.
